// File: rtl/mxv_pkg.sv
// Shared types for the MxV lane sequencer: byte type, lane selector and sequencer FSM states.
package mxv_pkg;

    typedef logic [7:0] uint8_t;

    localparam int MXV_LANES = 4;

    typedef logic [1:0] lane_sel_t;

    typedef enum logic {SEQ_IDLE, SEQ_ROW} seq_state_t;

    // Lane advance wraps 3 -> 0 through the 2-bit width.
    function automatic lane_sel_t lane_next(input lane_sel_t l);
        return l + 2'd1;
    endfunction

endpackage

// File: rtl/mxv_lane_sequencer_if.sv
// Stream-in / lane-out bundle of the MxV lane sequencer.
interface mxv_lane_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    import mxv_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    uint8_t           in_data;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    lane_sel_t        Selector;
    uint8_t           Data_input;
    logic             row_done;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, Selector, Data_input, row_done, fifo_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, Selector, Data_input, row_done, fifo_count
    );

endinterface

// File: rtl/mxv_byte_fifo.sv
// Show-ahead byte FIFO: head entry is visible whenever the FIFO is non-empty.
module mxv_byte_fifo
    import mxv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  uint8_t        data_i,
    input  logic          pop_i,
    output uint8_t        head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    uint8_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Guarded locally too, so the count can never over/underflow.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mxv_lane_sequencer.sv
// Buffers an upstream byte stream and issues it element by element onto lanes 0..3,
// flagging the completion of each 4-element row.
module mxv_lane_sequencer
    import mxv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_abort,
    mxv_lane_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam lane_sel_t LAST_LANE = lane_sel_t'(MXV_LANES - 1);

    uint8_t           head;
    logic [CNT_W-1:0] count;
    logic             full, empty;
    logic             push, pop;

    seq_state_t state_q, state_d;
    lane_sel_t  lane_q,  lane_d;
    logic       row_done_q, row_done_d;

    // in_ready is held low while reset is asserted.
    assign bus.in_ready   = rst_n && !full;
    assign bus.out_valid  = !empty;
    assign bus.Data_input = bus.out_valid ? head : '0;
    assign bus.Selector   = lane_q;
    assign bus.row_done   = row_done_q;
    assign bus.fifo_count = count;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    mxv_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (row_abort),
        .push_i  (push),
        .data_i  (bus.in_data),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_IDLE;
            lane_q     <= '0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            row_done_q <= row_done_d;
        end
    end

    // An empty FIFO mid-row simply leaves the lane parked in SEQ_ROW.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        row_done_d = 1'b0;
        if (row_abort) begin
            state_d = SEQ_IDLE;
            lane_d  = '0;
        end else if (pop) begin
            lane_d     = lane_next(lane_q);
            row_done_d = (lane_q == LAST_LANE);
            case (state_q)
                SEQ_IDLE: if (lane_q == '0)       state_d = SEQ_ROW;
                SEQ_ROW:  if (lane_q == LAST_LANE) state_d = SEQ_IDLE;
                default:  state_d = SEQ_IDLE;
            endcase
        end
    end

endmodule
